// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shift unit: op codes, FSM states,
// default widths and an op-legality helper.
package shift_pkg;

    localparam int SHIFT_WIDTH = 8;
    localparam int SHIFT_AMT_W = 3;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Codes above ROL are not shifts; the FSM treats them as a zero-amount op.
    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_ROL);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit step for the shift FSM; out_bit_o is the bit that
// leaves the register on this step (zero for non-shift codes).
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] r_i,
    output logic [WIDTH-1:0] next_r_o,
    output logic             out_bit_o
);

    always_comb begin
        next_r_o  = r_i;
        out_bit_o = 1'b0;
        case (op_i)
            OP_SLL: begin
                next_r_o  = {r_i[WIDTH-2:0], 1'b0};
                out_bit_o = r_i[WIDTH-1];
            end
            OP_SRL: begin
                next_r_o  = {1'b0, r_i[WIDTH-1:1]};
                out_bit_o = r_i[0];
            end
            OP_SRA: begin
                next_r_o  = {r_i[WIDTH-1], r_i[WIDTH-1:1]};
                out_bit_o = r_i[0];
            end
            OP_ROR: begin
                next_r_o  = {r_i[0], r_i[WIDTH-1:1]};
                out_bit_o = r_i[0];
            end
            OP_ROL: begin
                next_r_o  = {r_i[WIDTH-2:0], r_i[WIDTH-1]};
                out_bit_o = r_i[WIDTH-1];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Handshaked multi-cycle shifter: one bit per clock, RESULT published on FIN.
// Define SHIFT_CARRY_EN to add the CARRY output (last bit shifted out).
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int AMT_W = SHIFT_AMT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] DATA,
    input  logic [AMT_W-1:0] SHIFT,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
`ifdef SHIFT_CARRY_EN
    ,
    output logic             CARRY
`endif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] step_r;

`ifdef SHIFT_CARRY_EN
    logic             carry_q, carry_d;
    logic             step_carry;
`else
    logic             step_carry_unused;
`endif

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op_i      (op_q),
        .r_i       (work_q),
        .next_r_o  (step_r),
`ifdef SHIFT_CARRY_EN
        .out_bit_o (step_carry)
`else
        .out_bit_o (step_carry_unused)
`endif
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
`ifdef SHIFT_CARRY_EN
        carry_d  = carry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    op_d   = OP;
                    work_d = DATA;
                    cnt_d  = SHIFT;
                    // Zero amount and non-shift codes finish without stepping.
                    if ((SHIFT == '0) || !op_legal(OP)) begin
                        state_d  = ST_FIN;
                        result_d = DATA;
`ifdef SHIFT_CARRY_EN
                        carry_d  = 1'b0;
`endif
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                work_d = step_r;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d  = ST_FIN;
                    result_d = step_r;
`ifdef SHIFT_CARRY_EN
                    carry_d  = step_carry;
`endif
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            op_q     <= OP_SLL;
            result_q <= '0;
`ifdef SHIFT_CARRY_EN
            carry_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
`ifdef SHIFT_CARRY_EN
            carry_q  <= carry_d;
`endif
        end
    end

    assign BUSY   = (state_q == ST_RUN);
    assign DONE   = (state_q == ST_FIN);
    assign RESULT = result_q;
`ifdef SHIFT_CARRY_EN
    assign CARRY  = carry_q;
`endif

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: expected results are queued at issue time
// and popped by a DONE monitor that checks value, carry and completion cycle.
module tb_seq_shift_unit;

    typedef struct {
        logic [7:0] res;
        logic       carry;
        int         cyc;
    } exp_t;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic [2:0] OP;
    logic [7:0] DATA;
    logic [2:0] SHIFT;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;
`ifdef SHIFT_CARRY_EN
    logic       CARRY;
`endif

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];
    logic [7:0] last_res = 8'h00;

    seq_shift_unit #(.WIDTH(8), .AMT_W(3)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .OP     (OP),
        .DATA   (DATA),
        .SHIFT  (SHIFT),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
`ifdef SHIFT_CARRY_EN
        ,
        .CARRY  (CARRY)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference built from whole-word shift operators rather than stepping.
    function automatic exp_t model(input logic [2:0] op, input logic [7:0] d, input int n);
        exp_t e;
        e.res   = d;
        e.carry = 1'b0;
        e.cyc   = 0;
        if (op <= 3'd4 && n != 0) begin
            case (op)
                3'd0: begin e.res = d << n; e.carry = d[8-n]; end
                3'd1: begin e.res = d >> n; e.carry = d[n-1]; end
                3'd2: begin e.res = 8'($signed(d) >>> n); e.carry = d[n-1]; end
                3'd3: begin e.res = (d >> n) | (d << (8 - n)); e.carry = d[n-1]; end
                default: begin e.res = (d << n) | (d >> (8 - n)); e.carry = d[8-n]; end
            endcase
        end
        return e;
    endfunction

    always @(negedge CLK) begin
        if (RESET && DONE) begin
            check("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("result", 32'(RESULT), 32'(e.res));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("busy_at_done", 32'(BUSY), 32'd0);
`ifdef SHIFT_CARRY_EN
                check("carry", 32'(CARRY), 32'(e.carry));
`endif
            end
        end
    end

    // Drives one START cycle; returns at the negedge after the sampling edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] d, input int n, input bit accepted);
        exp_t e;
        int   neff;
        @(negedge CLK);
        OP    = op;
        DATA  = d;
        SHIFT = n[2:0];
        START = 1'b1;
        if (accepted) begin
            neff  = (op <= 3'd4) ? n : 0;
            e     = model(op, d, n);
            e.cyc = cyc + 1 + neff;
            sb.push_back(e);
            last_res = e.res;
        end
        @(negedge CLK);
        START = 1'b0;
        OP    = 3'($urandom);
        DATA  = 8'($urandom);
        SHIFT = 3'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge CLK);
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] prev;
        RESET = 1'b0;
        START = 1'b0;
        OP    = 3'd0;
        DATA  = 8'h00;
        SHIFT = 3'd0;
        repeat (2) @(negedge CLK);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_result", 32'(RESULT), 32'd0);
`ifdef SHIFT_CARRY_EN
        check("rst_carry", 32'(CARRY), 32'd0);
`endif
        RESET = 1'b1;

        // SRA by 3: BUSY for three cycles, RESULT holds the old value meanwhile.
        prev = last_res;
        issue(3'd2, 8'hB4, 3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("sra_busy", 32'(BUSY), 32'd1);
            check("sra_no_done", 32'(DONE), 32'd0);
            check("sra_result_hold", 32'(RESULT), 32'(prev));
            @(negedge CLK);
        end
        drain();

        issue(3'd4, 8'h81, 1, 1'b1); drain();
        issue(3'd3, 8'h81, 1, 1'b1); drain();
        issue(3'd7, 8'h81, 5, 1'b1); drain();
        issue(3'd0, 8'h01, 7, 1'b1); drain();
        issue(3'd1, 8'h01, 0, 1'b1); drain();

        // START during RUN must be dropped; a second DONE would hit an empty queue.
        issue(3'd0, 8'h35, 5, 1'b1);
        issue(3'd0, 8'hFF, 3, 1'b0);
        drain();
        repeat (8) @(negedge CLK);
        check("ignored_start_result", 32'(RESULT), 32'(last_res));

        // Asynchronous reset in the middle of a 6-step SRA.
        issue(3'd2, 8'h9C, 6, 1'b1);
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        check("midrst_busy", 32'(BUSY), 32'd0);
        check("midrst_done", 32'(DONE), 32'd0);
        check("midrst_result", 32'(RESULT), 32'd0);
        sb.delete();
        last_res = 8'h00;
        @(negedge CLK);
        #2 RESET = 1'b1;
        repeat (10) @(negedge CLK);
        check("post_rst_result", 32'(RESULT), 32'd0);
        issue(3'd1, 8'hC3, 2, 1'b1); drain();

        // Carry-oriented cases.
        issue(3'd1, 8'h81, 1, 1'b1); drain();
        issue(3'd0, 8'h81, 2, 1'b1); drain();
        issue(3'd4, 8'h81, 0, 1'b1); drain();
        issue(3'd4, 8'hA5, 3, 1'b1); drain();

        // Mixed ops, each issued in the first IDLE cycle after the previous DONE.
        for (int i = 0; i < 12; i++) begin
            issue(3'($urandom_range(0, 7)), 8'($urandom), int'($urandom_range(0, 7)), 1'b1);
            drain();
        end
        repeat (3) @(negedge CLK);
        check("final_hold", 32'(RESULT), 32'(last_res));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
